// File: rtl/bcd_time_loader.sv
// Sequential BCD-to-binary converter for presetting a binary timer count.
// One digit per cycle, MSB first, with invalid-digit and overflow flags.
module bcd_time_loader #(
    parameter int BCD_CNT   = 2,
    parameter int BIN_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*BCD_CNT-1:0]   bcd_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIN_WIDTH-1:0]   bin_code,
    output logic                   err,
    output logic                   ovf
);

    localparam int DW = 4 * BCD_CNT;
    localparam int AW = BIN_WIDTH + 4;
    localparam int IW = $clog2(BCD_CNT) + 1;
    localparam logic [AW-1:0] MAX_VAL  = {4'b0000, {BIN_WIDTH{1'b1}}};
    localparam logic [IW-1:0] LAST_IDX = IW'(BCD_CNT - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state;
    logic [DW-1:0]   data;
    logic [AW-1:0]   acc;
    logic [IW-1:0]   idx;
    logic            err_pend;

    logic            bad_digit;
    logic [3:0]      digit;
    logic [AW-1:0]   acc_next;
    logic            next_ovf;

    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < BCD_CNT; i++) begin
            if (bcd_code[4*i +: 4] > 4'd9)
                bad_digit = 1'b1;
        end
    end

    // acc stays clamped to MAX_VAL, so acc*10+9 always fits in AW bits.
    always_comb begin
        digit    = data[DW-1 -: 4];
        acc_next = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, digit};
        next_ovf = acc_next > MAX_VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bin_code  <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            data      <= '0;
            acc       <= '0;
            idx       <= '0;
            err_pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data     <= bcd_code;
                        acc      <= '0;
                        idx      <= '0;
                        ovf      <= 1'b0;
                        err      <= 1'b0;
                        bin_code <= '0;
                        err_pend <= bad_digit;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    if (err_pend) begin
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        data <= data << 4;
                        idx  <= idx + 1'b1;
                        if (next_ovf) begin
                            acc <= MAX_VAL;
                            ovf <= 1'b1;
                        end else begin
                            acc <= acc_next;
                        end
                        if (idx == LAST_IDX) begin
                            bin_code  <= (next_ovf || ovf) ? '1 : acc_next[BIN_WIDTH-1:0];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_time_loader.sv
// Directed bench for bcd_time_loader: a 2-digit and a 3-digit instance checked
// against a decimal-arithmetic reference model.
module tb_bcd_time_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv2 = 1'b0, or2 = 1'b1;
    logic [7:0]  bcd2 = '0;
    logic        ir2, ov2, err2, ovf2;
    logic [7:0]  bin2;

    logic        iv3 = 1'b0, or3 = 1'b1;
    logic [11:0] bcd3 = '0;
    logic        ir3, ov3, err3, ovf3;
    logic [7:0]  bin3;

    int errors = 0;
    int checks = 0;

    logic [7:0] eb2, eb3;
    logic       ee2, ee3, eo2, eo3;

    always #5 clk = ~clk;

    bcd_time_loader #(.BCD_CNT(2), .BIN_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .bcd_code(bcd2),
        .out_valid(ov2), .out_ready(or2), .bin_code(bin2), .err(err2), .ovf(ovf2)
    );

    bcd_time_loader #(.BCD_CNT(3), .BIN_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .bcd_code(bcd3),
        .out_valid(ov3), .out_ready(or3), .bin_code(bin3), .err(err3), .ovf(ovf3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal value of the digits, then range/validity rules.
    task automatic model(input logic [11:0] bcd, input int cnt,
                         output logic [7:0] b, output logic e, output logic o);
        int val;
        logic [11:0] v;
        v = bcd;
        val = 0;
        e = 1'b0;
        for (int i = cnt - 1; i >= 0; i--) begin
            if (v[4*i +: 4] > 4'd9) e = 1'b1;
            val = val * 10 + int'(v[4*i +: 4]);
        end
        if (e) begin
            b = 8'h00; o = 1'b0;
        end else if (val > 255) begin
            b = 8'hFF; o = 1'b1;
        end else begin
            b = 8'(val); o = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ov2) begin
            chk("d2_bin", {24'b0, bin2}, {24'b0, eb2});
            chk("d2_err", {31'b0, err2}, {31'b0, ee2});
            chk("d2_ovf", {31'b0, ovf2}, {31'b0, eo2});
            chk("d2_in_ready_done", {31'b0, ir2}, 32'd0);
        end
        if (!rst && ov3) begin
            chk("d3_bin", {24'b0, bin3}, {24'b0, eb3});
            chk("d3_err", {31'b0, err3}, {31'b0, ee3});
            chk("d3_ovf", {31'b0, ovf3}, {31'b0, eo3});
            chk("d3_in_ready_done", {31'b0, ir3}, 32'd0);
        end
    end

    function automatic logic get_ov(input int sel);
        return (sel == 2) ? ov2 : ov3;
    endfunction

    function automatic logic get_ir(input int sel);
        return (sel == 2) ? ir2 : ir3;
    endfunction

    // Called #1 after a rising edge with the selected DUT idle.
    task automatic send(input int sel, input logic [11:0] bcd, input bit hold);
        logic [7:0] b;
        logic e, o;
        int lat, k;
        model(bcd, sel, b, e, o);
        if (sel == 2) begin eb2 = b; ee2 = e; eo2 = o; end
        else          begin eb3 = b; ee3 = e; eo3 = o; end
        lat = e ? 1 : sel;
        chk("in_ready_idle", {31'b0, get_ir(sel)}, 32'd1);
        if (sel == 2) begin iv2 = 1'b1; bcd2 = bcd[7:0]; or2 = !hold; end
        else          begin iv3 = 1'b1; bcd3 = bcd;      or3 = !hold; end
        @(posedge clk); #1;
        if (sel == 2) begin iv2 = 1'b0; bcd2 = 8'hFF; end
        else          begin iv3 = 1'b0; bcd3 = 12'hFFF; end
        k = 0;
        while (!get_ov(sel) && k < 20) begin
            chk("in_ready_busy", {31'b0, get_ir(sel)}, 32'd0);
            @(posedge clk); #1;
            k++;
        end
        chk("latency", k, lat);
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                if (sel == 2) iv2 = c[0]; else iv3 = c[0];
                @(posedge clk); #1;
                chk("held_out_valid", {31'b0, get_ov(sel)}, 32'd1);
            end
            if (sel == 2) begin iv2 = 1'b0; or2 = 1'b1; end
            else          begin iv3 = 1'b0; or3 = 1'b1; end
        end
        @(posedge clk); #1;
        chk("out_valid_drop", {31'b0, get_ov(sel)}, 32'd0);
        chk("in_ready_back", {31'b0, get_ir(sel)}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        logic e, o;

        // Pin the model against hand-computed values.
        model(12'h099, 2, b, e, o);
        chk("model_99", {22'b0, b, e, o}, {22'b0, 8'h63, 1'b0, 1'b0});
        model(12'h300, 3, b, e, o);
        chk("model_300", {22'b0, b, e, o}, {22'b0, 8'hFF, 1'b0, 1'b1});
        model(12'h01A, 2, b, e, o);
        chk("model_1A", {22'b0, b, e, o}, {22'b0, 8'h00, 1'b1, 1'b0});
        model(12'h255, 3, b, e, o);
        chk("model_255", {22'b0, b, e, o}, {22'b0, 8'hFF, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, ir2}, 32'd1);
        chk("rst_out_valid", {31'b0, ov2}, 32'd0);
        chk("rst_bin", {24'b0, bin2}, 32'd0);
        chk("rst_flags", {30'b0, err2, ovf2}, 32'd0);
        chk("rst3_state", {28'b0, ir3, ov3, err3, ovf3}, 32'b1000);
        rst = 1'b0;
        @(posedge clk); #1;

        send(2, 12'h099, 1'b0);
        send(2, 12'h000, 1'b0);
        send(2, 12'h007, 1'b0);
        send(2, 12'h01A, 1'b0);
        send(2, 12'h0A3, 1'b0);
        send(2, 12'h042, 1'b1);

        send(3, 12'h255, 1'b0);
        send(3, 12'h300, 1'b0);
        send(3, 12'h999, 1'b0);
        send(3, 12'h256, 1'b0);
        send(3, 12'h099, 1'b0);
        send(3, 12'h9B0, 1'b0);
        send(3, 12'h000, 1'b0);

        // Reset while 8'h45 is mid-conversion.
        iv2 = 1'b1; bcd2 = 8'h45;
        @(posedge clk); #1;
        iv2 = 1'b0;
        @(posedge clk); #1;
        chk("mid_conv_busy", {31'b0, ir2}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'b0, ov2}, 32'd0);
        chk("midrst_bin", {24'b0, bin2}, 32'd0);
        chk("midrst_in_ready", {31'b0, ir2}, 32'd1);
        send(2, 12'h012, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
